// File: rtl/jbi_pktin_dasm_if.sv
// rtl/jbi_pktin_dasm_if.sv - JBus pin sample inputs and packet-out beat stream for jbi_pktin_dasm
// The slave side is the disassembler; the master side drives the pins and consumes the beats.
interface jbi_pktin_dasm_if;
  logic [7:0]   io_jbi_j_adtype;
  logic [127:0] io_jbi_j_ad;
  logic [3:0]   io_jbi_j_adp;
  logic         pktin_rdy;
  logic         pktin_vld;
  logic [127:0] pktin_data;
  logic         pktin_hdr;
  logic         pktin_last;
  logic [3:0]   pktin_type;
  logic         pktin_err_par;
  logic         pktin_err_proto;
  logic         pktin_err_ovf;
  logic [4:0]   pktin_level;

  modport master (
    output io_jbi_j_adtype, io_jbi_j_ad, io_jbi_j_adp, pktin_rdy,
    input  pktin_vld, pktin_data, pktin_hdr, pktin_last, pktin_type,
    input  pktin_err_par, pktin_err_proto, pktin_err_ovf, pktin_level
  );

  modport slave (
    input  io_jbi_j_adtype, io_jbi_j_ad, io_jbi_j_adp, pktin_rdy,
    output pktin_vld, pktin_data, pktin_hdr, pktin_last, pktin_type,
    output pktin_err_par, pktin_err_proto, pktin_err_ovf, pktin_level
  );
endinterface

// File: rtl/jbi_pktin_dasm.sv
// rtl/jbi_pktin_dasm.sv - JBus inbound cycle disassembler with a 16-entry packet staging FIFO
// Beats are staged at a speculative pointer and become visible only when the packet completes cleanly.
module jbi_pktin_dasm (
  input  logic            clk,
  input  logic            rst_l,
  jbi_pktin_dasm_if.slave bus
);
  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  state_t       r_state;
  logic [7:0]   r_adtype;
  logic [127:0] r_ad;
  logic [3:0]   r_adp;
  logic [2:0]   r_cnt;
  logic         r_drop;
  logic [3:0]   r_pkt_type;
  logic [3:0]   r_wr_spec;
  logic [3:0]   r_wr_cmt;
  logic [3:0]   r_rd;
  logic [4:0]   r_level;
  logic         r_err_par;
  logic         r_err_proto;
  logic         r_err_ovf;

  logic [127:0] r_mem_data [16];
  logic         r_mem_hdr  [16];
  logic         r_mem_last [16];
  logic [3:0]   r_mem_type [16];

  logic         w_is_idle;
  logic         w_is_addr;
  logic         w_is_data;
  logic         w_par_ok;
  logic         w_type_ok;
  logic [3:0]   w_type;
  logic [2:0]   w_beats;

  assign w_is_idle = (r_adtype == 8'h00);
  assign w_is_addr = r_adtype[7];
  assign w_is_data = (r_adtype[7:6] == 2'b01);
  assign w_type    = r_adtype[3:0];

  // Odd parity per 32-bit lane; lane 0 also covers ADTYPE.
  assign w_par_ok = (^r_ad[31:0]   ^ r_adp[0] ^ (^r_adtype)) &
                    (^r_ad[63:32]  ^ r_adp[1]) &
                    (^r_ad[95:64]  ^ r_adp[2]) &
                    (^r_ad[127:96] ^ r_adp[3]);

  always_comb begin
    w_type_ok = 1'b1;
    w_beats   = 3'd0;
    case (w_type)
      4'h1:    w_beats = 3'd0;
      4'h2:    w_beats = 3'd4;
      4'h3:    w_beats = 3'd1;
      4'h4:    w_beats = 3'd4;
      default: w_type_ok = 1'b0;
    endcase
  end

  logic         w_vld;
  logic         w_pop;
  logic         w_we;
  logic [3:0]   w_wptr;
  logic         w_whdr;
  logic         w_wlast;
  logic [3:0]   w_wtype;
  logic [3:0]   w_base;
  logic [3:0]   w_uncmt;
  logic [4:0]   w_free;
  logic         w_ovf_hit;
  logic [3:0]   w_spec_nxt;
  logic [3:0]   w_cmt_nxt;
  logic [3:0]   w_ncommit;
  state_t       w_state_nxt;
  logic [2:0]   w_cnt_nxt;
  logic         w_drop_nxt;
  logic [3:0]   w_type_nxt;
  logic         w_par_err;
  logic         w_proto_err;
  logic         w_ovf_err;

  assign w_vld = (r_level != 5'd0);
  assign w_pop = w_vld & bus.pktin_rdy;

  always_comb begin
    w_we        = 1'b0;
    w_wptr      = r_wr_spec;
    w_whdr      = 1'b0;
    w_wlast     = 1'b0;
    w_wtype     = r_pkt_type;
    w_spec_nxt  = r_wr_spec;
    w_cmt_nxt   = r_wr_cmt;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drop_nxt  = r_drop;
    w_type_nxt  = r_pkt_type;
    w_par_err   = 1'b0;
    w_proto_err = 1'b0;
    w_ovf_err   = 1'b0;
    w_base      = r_wr_spec;
    w_uncmt     = r_wr_spec - r_wr_cmt;
    // An address cycle that interrupts a packet discards the partial packet before it is judged.
    if (w_is_addr && (r_state == ST_DATA)) begin
      w_proto_err = 1'b1;
      w_base      = r_wr_cmt;
      w_uncmt     = 4'd0;
    end
    w_free    = 5'd16 - r_level - {1'b0, w_uncmt};
    w_ovf_hit = ({2'b00, w_beats} + 5'd1) > w_free;

    if (w_is_addr) begin
      w_spec_nxt  = w_base;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
      w_drop_nxt  = 1'b0;
      if (!w_type_ok) begin
        w_proto_err = 1'b1;
      end else begin
        w_type_nxt = w_type;
        w_par_err  = ~w_par_ok;
        w_ovf_err  = w_ovf_hit;
        if (w_beats != 3'd0) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = w_beats;
          w_drop_nxt  = ~w_par_ok | w_ovf_hit;
        end
        if (w_par_ok && !w_ovf_hit) begin
          w_we       = 1'b1;
          w_wptr     = w_base;
          w_whdr     = 1'b1;
          w_wlast    = (w_beats == 3'd0);
          w_wtype    = w_type;
          w_spec_nxt = w_base + 4'd1;
          if (w_beats == 3'd0) w_cmt_nxt = w_base + 4'd1;
        end
      end
    end else if (w_is_data) begin
      if (r_state == ST_IDLE) begin
        w_proto_err = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_state_nxt = ST_IDLE;
        if (!r_drop) begin
          if (!w_par_ok) begin
            w_par_err  = 1'b1;
            w_spec_nxt = r_wr_cmt;
            w_drop_nxt = 1'b1;
          end else begin
            w_we       = 1'b1;
            w_wlast    = (r_cnt == 3'd1);
            w_spec_nxt = r_wr_spec + 4'd1;
            if (r_cnt == 3'd1) w_cmt_nxt = r_wr_spec + 4'd1;
          end
        end
      end
    end else if (!w_is_idle) begin
      w_proto_err = 1'b1;
    end
  end

  assign w_ncommit = w_cmt_nxt - r_wr_cmt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_adtype    <= 8'h00;
      r_ad        <= '0;
      r_adp       <= 4'h0;
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_drop      <= 1'b0;
      r_pkt_type  <= 4'h0;
      r_wr_spec   <= 4'd0;
      r_wr_cmt    <= 4'd0;
      r_rd        <= 4'd0;
      r_level     <= 5'd0;
      r_err_par   <= 1'b0;
      r_err_proto <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_adtype    <= bus.io_jbi_j_adtype;
      r_ad        <= bus.io_jbi_j_ad;
      r_adp       <= bus.io_jbi_j_adp;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_drop      <= w_drop_nxt;
      r_pkt_type  <= w_type_nxt;
      r_wr_spec   <= w_spec_nxt;
      r_wr_cmt    <= w_cmt_nxt;
      r_rd        <= r_rd + {3'd0, w_pop};
      r_level     <= r_level + {1'b0, w_ncommit} - {4'd0, w_pop};
      r_err_par   <= w_par_err;
      r_err_proto <= w_proto_err;
      r_err_ovf   <= w_ovf_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem_data[w_wptr] <= r_ad;
      r_mem_hdr[w_wptr]  <= w_whdr;
      r_mem_last[w_wptr] <= w_wlast;
      r_mem_type[w_wptr] <= w_wtype;
    end
  end

  assign bus.pktin_vld       = w_vld;
  assign bus.pktin_data      = w_vld ? r_mem_data[r_rd] : 128'd0;
  assign bus.pktin_hdr       = w_vld ? r_mem_hdr[r_rd]  : 1'b0;
  assign bus.pktin_last      = w_vld ? r_mem_last[r_rd] : 1'b0;
  assign bus.pktin_type      = w_vld ? r_mem_type[r_rd] : 4'h0;
  assign bus.pktin_err_par   = r_err_par;
  assign bus.pktin_err_proto = r_err_proto;
  assign bus.pktin_err_ovf   = r_err_ovf;
  assign bus.pktin_level     = r_level;
endmodule

// File: tb/tb_jbi_pktin_dasm.sv
// tb/tb_jbi_pktin_dasm.sv - directed self-checking bench for jbi_pktin_dasm
module tb_jbi_pktin_dasm;
  logic clk = 1'b0;
  logic rst_l;

  jbi_pktin_dasm_if bus ();

  jbi_pktin_dasm dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         h;
    logic         l;
    logic [3:0]   t;
  } beat_t;

  beat_t q[$];
  int    n_tot = 0;
  int    n_bad = 0;
  int    n_par = 0;
  int    n_proto = 0;
  int    n_ovf = 0;
  int    lvl_peak = 0;
  int    s_par, s_proto, s_ovf;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int n);
    return {32'(n) * 32'h01010101, ~32'(n), 32'h5A5A0000 + 32'(n), 32'(n)};
  endfunction

  function automatic logic [3:0] good_adp(input logic [7:0] t, input logic [127:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ~(^d[32*i +: 32]);
    p[0] = ~((^d[31:0]) ^ (^t));
    return p;
  endfunction

  function automatic beat_t get(input int i);
    beat_t b;
    b = '{d: '0, h: 1'b0, l: 1'b0, t: 4'h0};
    if (i < q.size()) b = q[i];
    return b;
  endfunction

  // Records what the consumer sees this cycle, then advances one clock.
  task automatic tick();
    if (bus.pktin_vld && bus.pktin_rdy)
      q.push_back('{d: bus.pktin_data, h: bus.pktin_hdr, l: bus.pktin_last, t: bus.pktin_type});
    if (bus.pktin_err_par)   n_par++;
    if (bus.pktin_err_proto) n_proto++;
    if (bus.pktin_err_ovf)   n_ovf++;
    @(posedge clk);
    #1;
    if (int'(bus.pktin_level) > lvl_peak) lvl_peak = int'(bus.pktin_level);
  endtask

  task automatic drive(input logic [7:0] t, input logic [127:0] d, input logic [3:0] flip);
    bus.io_jbi_j_adtype = t;
    bus.io_jbi_j_ad     = d;
    bus.io_jbi_j_adp    = good_adp(t, d) ^ flip;
    tick();
  endtask

  task automatic idle(input int n);
    bus.io_jbi_j_adtype = 8'h00;
    bus.io_jbi_j_ad     = '0;
    bus.io_jbi_j_adp    = 4'h0;
    repeat (n) tick();
  endtask

  task automatic snap();
    s_par = n_par;
    s_proto = n_proto;
    s_ovf = n_ovf;
  endtask

  beat_t b;

  initial begin
    rst_l = 1'b0;
    bus.pktin_rdy = 1'b0;
    idle(3);
    chk("rst_vld",   bus.pktin_vld, 0);
    chk("rst_level", bus.pktin_level, 0);
    chk("rst_data",  bus.pktin_data, 0);
    chk("rst_hdr",   bus.pktin_hdr, 0);
    chk("rst_last",  bus.pktin_last, 0);
    chk("rst_type",  bus.pktin_type, 0);
    chk("rst_errs",  {bus.pktin_err_par, bus.pktin_err_proto, bus.pktin_err_ovf}, 0);
    rst_l = 1'b1;
    idle(2);

    // single RD header, consumer ready
    bus.pktin_rdy = 1'b1;
    q.delete();
    drive(8'h81, mk(1), 4'h0);
    idle(1);
    chk("rd_vld",   bus.pktin_vld, 1);
    chk("rd_hdr",   bus.pktin_hdr, 1);
    chk("rd_last",  bus.pktin_last, 1);
    chk("rd_type",  bus.pktin_type, 4'h1);
    chk("rd_data",  bus.pktin_data, mk(1));
    chk("rd_level", bus.pktin_level, 1);
    idle(1);
    chk("rd_level_after", bus.pktin_level, 0);
    chk("rd_popped", q.size(), 1);

    // WRI with idle gaps, consumer stalled
    bus.pktin_rdy = 1'b0;
    q.delete();
    lvl_peak = 0;
    drive(8'h82, mk(16), 4'h0);
    drive(8'h40, mk(17), 4'h0);
    idle(1);
    drive(8'h40, mk(18), 4'h0);
    drive(8'h40, mk(19), 4'h0);
    idle(1);
    drive(8'h40, mk(20), 4'h0);
    chk("wri_uncommitted", bus.pktin_level, 0);
    idle(1);
    chk("wri_level", bus.pktin_level, 5);
    chk("wri_peak",  lvl_peak, 5);
    chk("wri_hdr",   bus.pktin_hdr, 1);
    chk("wri_type",  bus.pktin_type, 4'h2);
    chk("wri_head",  bus.pktin_data, mk(16));
    idle(1);
    chk("wri_stable", bus.pktin_data, mk(16));
    bus.pktin_rdy = 1'b1;
    idle(7);
    chk("wri_count", q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      b = get(i);
      chk($sformatf("wri_d%0d", i), b.d, mk(16 + i));
      chk($sformatf("wri_l%0d", i), b.l, (i == 4));
      chk($sformatf("wri_h%0d", i), b.h, (i == 0));
    end
    chk("wri_drained", bus.pktin_level, 0);

    // WRI with parity fault on data beat 3, then RD
    q.delete();
    lvl_peak = 0;
    snap();
    drive(8'h82, mk(32), 4'h0);
    drive(8'h40, mk(33), 4'h0);
    drive(8'h40, mk(34), 4'h0);
    drive(8'h40, mk(35), 4'b0100);
    drive(8'h40, mk(36), 4'h0);
    idle(3);
    chk("par_pulse", n_par - s_par, 1);
    chk("par_none_out", q.size(), 0);
    chk("par_level", lvl_peak, 0);
    chk("par_no_proto", n_proto - s_proto, 0);
    drive(8'h81, mk(37), 4'h0);
    idle(3);
    b = get(0);
    chk("par_rd_count", q.size(), 1);
    chk("par_rd_data", b.d, mk(37));
    chk("par_rd_last", b.l, 1);

    // fill 15 entries, WRM overflows, RD fits the last slot
    bus.pktin_rdy = 1'b0;
    q.delete();
    snap();
    for (int k = 0; k < 3; k++) begin
      drive(8'h82, mk(48 + 5 * k), 4'h0);
      for (int j = 1; j < 5; j++) drive(8'h40, mk(48 + 5 * k + j), 4'h0);
    end
    drive(8'h83, mk(63), 4'h0);
    drive(8'h40, mk(64), 4'h0);
    idle(2);
    chk("ovf_pulse", n_ovf - s_ovf, 1);
    chk("ovf_level", bus.pktin_level, 15);
    chk("ovf_no_proto", n_proto - s_proto, 0);
    drive(8'h81, mk(65), 4'h0);
    idle(2);
    chk("ovf_full", bus.pktin_level, 16);
    chk("ovf_once", n_ovf - s_ovf, 1);
    bus.pktin_rdy = 1'b1;
    idle(20);
    chk("ovf_count", q.size(), 16);
    b = get(0);
    chk("ovf_first", b.d, mk(48));
    b = get(14);
    chk("ovf_15th", b.d, mk(62));
    b = get(15);
    chk("ovf_rd", b.d, mk(65));
    chk("ovf_drained", bus.pktin_level, 0);

    // address cycle interrupts WRI
    q.delete();
    snap();
    drive(8'h82, mk(80), 4'h0);
    drive(8'h40, mk(81), 4'h0);
    drive(8'h40, mk(82), 4'h0);
    drive(8'h81, mk(83), 4'h0);
    idle(4);
    b = get(0);
    chk("proto_pulse", n_proto - s_proto, 1);
    chk("proto_count", q.size(), 1);
    chk("proto_data", b.d, mk(83));
    chk("proto_type", b.t, 4'h1);
    chk("proto_hdr",  b.h, 1);

    // stray data and illegal adtype are discarded
    snap();
    drive(8'h40, mk(84), 4'h0);
    drive(8'h21, mk(85), 4'h0);
    drive(8'h85, mk(86), 4'h0);
    idle(3);
    chk("illegal_proto", n_proto - s_proto, 3);
    chk("illegal_level", bus.pktin_level, 0);

    // reset mid-packet with three committed entries
    bus.pktin_rdy = 1'b0;
    drive(8'h83, mk(96), 4'h0);
    drive(8'h40, mk(97), 4'h0);
    drive(8'h81, mk(98), 4'h0);
    idle(2);
    chk("rstm_level_pre", bus.pktin_level, 3);
    drive(8'h82, mk(99), 4'h0);
    drive(8'h40, mk(100), 4'h0);
    bus.io_jbi_j_adtype = 8'h40;
    bus.io_jbi_j_ad     = mk(101);
    bus.io_jbi_j_adp    = good_adp(8'h40, mk(101));
    #2 rst_l = 1'b0;
    #1;
    chk("rstm_level", bus.pktin_level, 0);
    chk("rstm_vld",   bus.pktin_vld, 0);
    snap();
    tick();
    tick();
    idle(1);
    rst_l = 1'b1;
    idle(4);
    chk("rstm_no_errs", (n_par - s_par) + (n_proto - s_proto) + (n_ovf - s_ovf), 0);
    chk("rstm_level_post", bus.pktin_level, 0);
    drive(8'h81, mk(102), 4'h0);
    idle(1);
    chk("rstm_rd_level", bus.pktin_level, 1);
    chk("rstm_rd_data",  bus.pktin_data, mk(102));
    chk("rstm_rd_hdr",   bus.pktin_hdr, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
